// File: rtl/imuldiv_int_div_iter_param_pkg.sv
// ---------------------------------------------------------------------------
// imuldiv_int_div_iter_param_pkg
//
// Shared definitions for the iterative muldiv units:
//   - DivReqMsg function encodings (unsigned / signed)
//   - 2-bit FSM state encodings (IDLE / CALC / DONE)
//   - response field layout helpers (remainder in upper half, quotient in lower)
// ---------------------------------------------------------------------------
package imuldiv_int_div_iter_param_pkg;

    // DivReqMsg function field
    localparam logic DivFnUnsigned = 1'b0;
    localparam logic DivFnSigned   = 1'b1;

    // Iterative unit control states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } div_state_e;

    // Response message is {remainder, quotient}; these give the half offsets
    // for an operand width w.
    function automatic int unsigned div_resp_quot_lsb(input int unsigned w);
        div_resp_quot_lsb = 0 * w;
    endfunction

    function automatic int unsigned div_resp_rem_lsb(input int unsigned w);
        div_resp_rem_lsb = w;
    endfunction

endpackage

// File: rtl/imuldiv_div_iter_counter.sv
// ---------------------------------------------------------------------------
// imuldiv_div_iter_counter
//
// Width-bit iteration down-counter shared by the iterative divide/multiply
// units. Load has priority over decrement.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset (count -> 0)
//   load_i      load load_val_i on the next rising edge
//   load_val_i  value to load
//   dec_i       decrement by one on the next rising edge
//   count_o     current count
//   zero_o      count == 0
// ---------------------------------------------------------------------------
module imuldiv_div_iter_counter #(
    parameter int unsigned Width = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] count_o,
    output logic             zero_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/imuldiv_int_div_iter_param.sv
// ---------------------------------------------------------------------------
// imuldiv_int_div_iter_param
//
// Parametrised iterative restoring divider, one quotient bit per cycle.
// Signed/unsigned per request; divide-by-zero and signed overflow follow the
// RISC-V M rules, with an extra divide-by-zero flag on the response.
//
// Build option: define IMULDIV_DIV_DBZ_FASTPATH_EN to skip the iterations for
// a zero divisor (response one cycle after accept, same result values).
//
// Ports:
//   clk                 clock, rising edge
//   reset_n             asynchronous active-low reset
//   divreq_msg_fn       0 = unsigned, 1 = signed
//   divreq_msg_a        dividend (W bits)
//   divreq_msg_b        divisor (W bits)
//   divreq_val/_rdy     request handshake (rdy only in IDLE)
//   divresp_msg_result  {remainder, quotient} (2W bits)
//   divresp_dbz         divide-by-zero flag, qualified by divresp_val
//   divresp_val/_rdy    response handshake (val only in DONE)
// ---------------------------------------------------------------------------
module imuldiv_int_div_iter_param
    import imuldiv_int_div_iter_param_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           divreq_msg_fn,
    input  logic [W-1:0]   divreq_msg_a,
    input  logic [W-1:0]   divreq_msg_b,
    input  logic           divreq_val,
    output logic           divreq_rdy,
    output logic [2*W-1:0] divresp_msg_result,
    output logic           divresp_dbz,
    output logic           divresp_val,
    input  logic           divresp_rdy
);

    localparam int unsigned CW      = $clog2(W);
    localparam int unsigned QuotLsb = div_resp_quot_lsb(W);
    localparam int unsigned RemLsb  = div_resp_rem_lsb(W);

    div_state_e state_q, state_d;

    logic           fn_q;
    logic           dbz_q;
    logic           qsign_q;
    logic           rsign_q;
    logic [W-1:0]   a_raw_q;
    logic [W-1:0]   b_mag_q;
    logic [2*W-1:0] rem_q, rem_d;

    logic           accept;
    logic           a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic           b_zero;
    logic           cnt_zero;
    logic [CW-1:0]  cnt_val;

    assign accept = (state_q == StIdle) && divreq_val;
    assign b_zero = (divreq_msg_b == '0);

    // Magnitudes: negate only for signed requests with a set MSB.
    assign a_neg = (divreq_msg_fn == DivFnSigned) && divreq_msg_a[W-1];
    assign b_neg = (divreq_msg_fn == DivFnSigned) && divreq_msg_b[W-1];
    assign a_mag = a_neg ? (~divreq_msg_a + W'(1)) : divreq_msg_a;
    assign b_mag = b_neg ? (~divreq_msg_b + W'(1)) : divreq_msg_b;

    imuldiv_div_iter_counter #(
        .Width (CW)
    ) u_counter (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .load_i     (accept),
        .load_val_i (CW'(W - 1)),
        .dec_i      (state_q == StCalc),
        .count_o    (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef IMULDIV_DIV_DBZ_FASTPATH_EN
                    state_d = b_zero ? StDone : StCalc;
`else
                    state_d = StCalc;
`endif
                end
            end
            StCalc: begin
                if (cnt_zero) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (divresp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Restoring step. The shifted value needs 2W+1 bits, but whenever its top
    // bit is set the trial subtract succeeds and the kept difference fits in
    // 2W bits, so only 2W bits are stored.
    logic [2*W:0] shifted;
    logic [2*W:0] diff;

    always_comb begin
        shifted = {rem_q, 1'b0};
        diff    = shifted - {1'b0, b_mag_q, {W{1'b0}}};
        rem_d   = rem_q;
        if (accept) begin
            rem_d = {{W{1'b0}}, a_mag};
        end else if (state_q == StCalc) begin
            if (!diff[2*W]) begin
                rem_d = diff[2*W-1:0] | {{(2*W-1){1'b0}}, 1'b1};
            end else begin
                rem_d = shifted[2*W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fn_q    <= DivFnUnsigned;
            dbz_q   <= 1'b0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            a_raw_q <= '0;
            b_mag_q <= '0;
        end else if (accept) begin
            fn_q    <= divreq_msg_fn;
            dbz_q   <= b_zero;
            qsign_q <= divreq_msg_a[W-1] ^ divreq_msg_b[W-1];
            rsign_q <= divreq_msg_a[W-1];
            a_raw_q <= divreq_msg_a;
            b_mag_q <= b_mag;
        end
    end

    // Response, combinational from registers and zero outside DONE.
    logic [W-1:0] quot_raw, rem_raw;
    logic [W-1:0] quot, rem;
    logic         is_signed;

    assign is_signed = (fn_q == DivFnSigned);
    assign quot_raw  = rem_q[QuotLsb +: W];
    assign rem_raw   = rem_q[RemLsb +: W];

    always_comb begin
        quot = (is_signed && qsign_q) ? (~quot_raw + W'(1)) : quot_raw;
        rem  = (is_signed && rsign_q) ? (~rem_raw + W'(1)) : rem_raw;
        if (dbz_q) begin
            quot = '1;
            rem  = a_raw_q;
        end
    end

    always_comb begin
        divreq_rdy         = (state_q == StIdle);
        divresp_val        = (state_q == StDone);
        divresp_msg_result = '0;
        divresp_dbz        = 1'b0;
        if (state_q == StDone) begin
            divresp_msg_result = {rem, quot};
            divresp_dbz        = dbz_q;
        end
    end

endmodule
